// File: rtl/fast_square_sweep_ctrl.sv
// Sweep sequencer: for each frequency point it waits for the LO to settle,
// aligns to the decimated sample stream, records a fixed number of samples, then steps.
module fast_square_sweep_ctrl #(
   parameter int STEP_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [STEP_W-1:0] num_steps,
   input  logic [CNT_W-1:0]  settle_cycles,
   input  logic [CNT_W-1:0]  record_samples,
   input  logic              data_out_strobe,
   output logic              freq_step,
   output logic              record,
   output logic [STEP_W-1:0] step_index,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      ALIGN,
      RECORD,
      STEP,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [STEP_W-1:0] steps_q;
   logic [CNT_W-1:0]  settle_q;
   logic [CNT_W-1:0]  target_q;
   logic [CNT_W-1:0]  settle_cnt;
   logic [CNT_W-1:0]  sample_cnt;
   logic [CNT_W-1:0]  sample_inc;
   logic              zero_done_q;
   logic              aborted_q;

   logic              start_ok;
   logic              take_abort;
   logic              record_last;
   logic              last_step;

   assign start_ok    = (state == IDLE) && start && !abort;
   assign take_abort  = abort && (state != IDLE);
   assign sample_inc  = (sample_cnt == '1) ? sample_cnt : sample_cnt + CNT_W'(1);
   assign record_last = data_out_strobe && (sample_inc >= target_q);
   assign last_step   = (step_index == steps_q - STEP_W'(1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (take_abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_ok && (num_steps != '0)) state_next = SETTLE;
            SETTLE:  if (settle_cnt <= CNT_W'(1)) state_next = ALIGN;
            ALIGN:   if (data_out_strobe) state_next = RECORD;
            RECORD:  if (record_last) state_next = last_step ? DONE : STEP;
            STEP:    state_next = SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Counters only move down to 1 / up to all-ones, so they saturate rather than wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         steps_q     <= '0;
         settle_q    <= '0;
         target_q    <= '0;
         settle_cnt  <= '0;
         sample_cnt  <= '0;
         step_index  <= '0;
         zero_done_q <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         zero_done_q <= start_ok && (num_steps == '0);
         aborted_q   <= take_abort;
         if (!take_abort) begin
            case (state)
               IDLE: begin
                  if (start_ok && (num_steps != '0)) begin
                     steps_q    <= num_steps;
                     settle_q   <= settle_cycles;
                     target_q   <= (record_samples == '0) ? CNT_W'(1) : record_samples;
                     settle_cnt <= settle_cycles;
                     step_index <= '0;
                  end
               end
               SETTLE: begin
                  if (settle_cnt > CNT_W'(1)) settle_cnt <= settle_cnt - CNT_W'(1);
               end
               ALIGN: begin
                  if (data_out_strobe) sample_cnt <= '0;
               end
               RECORD: begin
                  if (data_out_strobe) sample_cnt <= sample_inc;
               end
               STEP: begin
                  step_index <= step_index + STEP_W'(1);
                  settle_cnt <= settle_q;
               end
               default: ;
            endcase
         end
      end
   end

   // Every output is decoded from registered state only.
   always_comb begin
      busy      = (state != IDLE);
      record    = (state == RECORD);
      freq_step = (state == STEP);
      done      = (state == DONE) || zero_done_q;
      aborted   = aborted_q;
   end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed bench for fast_square_sweep_ctrl: a per-cycle vector table plus
// hand-timed sequences for the long sweep, abort, ignored inputs and reset mid-step.
module tb_fast_square_sweep_ctrl;

   logic        clock;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  num_steps;
   logic [15:0] settle_cycles;
   logic [15:0] record_samples;
   logic        data_out_strobe;
   logic        freq_step;
   logic        record;
   logic [7:0]  step_index;
   logic        busy;
   logic        done;
   logic        aborted;

   int tests;
   int failures;

   typedef struct {
      logic        rst;
      logic        st;
      logic        ab;
      logic [7:0]  ns;
      logic [15:0] sc;
      logic [15:0] rs;
      logic        strb;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[23];

   fast_square_sweep_ctrl #(.STEP_W(8), .CNT_W(16)) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .abort(abort),
      .num_steps(num_steps),
      .settle_cycles(settle_cycles),
      .record_samples(record_samples),
      .data_out_strobe(data_out_strobe),
      .freq_step(freq_step),
      .record(record),
      .step_index(step_index),
      .busy(busy),
      .done(done),
      .aborted(aborted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [12:0] pack_out(input logic f, input logic r, input logic [7:0] idx,
                                            input logic b, input logic d, input logic a);
      return {f, r, idx, b, d, a};
   endfunction

   function automatic logic [12:0] outs_now();
      return {freq_step, record, step_index, busy, done, aborted};
   endfunction

   task automatic wait_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      reset           = v.rst;
      start           = v.st;
      abort           = v.ab;
      num_steps       = v.ns;
      settle_cycles   = v.sc;
      record_samples  = v.rs;
      data_out_strobe = v.strb;
      wait_cycle();
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic set_cfg(input logic [7:0] ns, input logic [15:0] sc, input logic [15:0] rs);
      num_steps      = ns;
      settle_cycles  = sc;
      record_samples = rs;
   endtask

   initial begin
      int cyc;
      int windows, rec_strobes, freq_cnt, done_cnt, abort_cnt, busy_cnt, viol;
      int idx_seq;
      int first_rec_k, freq_k, done_k, idx_at_done, idx_at_k5;
      logic prev_rec, prev_freq, seen;

      tests = 0;
      failures = 0;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      data_out_strobe = 1'b0;
      set_cfg(8'd0, 16'd0, 16'd0);

      // rst st ab ns sc rs strb  -> {freq, rec, idx, busy, done, aborted}
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd0, 0, 0, 0)};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd0, 1, 0, 0)};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b1, pack_out(0, 0, 8'd0, 1, 0, 0)};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd0, 1, 0, 0)};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b1, pack_out(0, 1, 8'd0, 1, 0, 0)};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b1, pack_out(0, 1, 8'd0, 1, 0, 0)};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 1, 8'd0, 1, 0, 0)};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b1, pack_out(1, 0, 8'd0, 1, 0, 0)};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd1, 1, 0, 0)};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd1, 1, 0, 0)};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b1, pack_out(0, 1, 8'd1, 1, 0, 0)};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b1, pack_out(0, 1, 8'd1, 1, 0, 0)};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b1, pack_out(0, 0, 8'd1, 1, 1, 0)};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd1, 0, 0, 0)};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 8'd0, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd1, 0, 1, 0)};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 8'd0, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd1, 0, 0, 0)};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd1, 0, 0, 0)};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 8'd2, 16'd1, 16'd2, 1'b0, pack_out(0, 0, 8'd1, 0, 0, 0)};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 8'd1, 16'd0, 16'd0, 1'b0, pack_out(0, 0, 8'd0, 1, 0, 0)};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 8'd1, 16'd0, 16'd0, 1'b0, pack_out(0, 0, 8'd0, 1, 0, 0)};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 8'd1, 16'd0, 16'd0, 1'b1, pack_out(0, 1, 8'd0, 1, 0, 0)};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 8'd1, 16'd0, 16'd0, 1'b1, pack_out(0, 0, 8'd0, 1, 1, 0)};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 8'd1, 16'd0, 16'd0, 1'b0, pack_out(0, 0, 8'd0, 0, 0, 0)};

      for (int i = 0; i < 23; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), 32'(outs_now()), 32'(vecs[i].exp));
      end

      // Normal sweep: 3 points, settle 10, record 4, strobe every 17 clocks.
      windows = 0; rec_strobes = 0; freq_cnt = 0; done_cnt = 0; viol = 0; idx_seq = 0;
      prev_rec = 1'b0; prev_freq = 1'b0; seen = 1'b0;
      set_cfg(8'd3, 16'd10, 16'd4);
      start = 1'b1;
      for (cyc = 0; cyc < 1500 && !seen; cyc++) begin
         data_out_strobe = (cyc % 17 == 16);
         if (data_out_strobe && record) rec_strobes++;
         wait_cycle();
         start = 1'b0;
         if (record && !prev_rec) begin
            windows++;
            idx_seq = idx_seq * 16 + int'(step_index);
         end
         if (freq_step) freq_cnt++;
         if (freq_step && (record || prev_freq)) viol++;
         if (done) begin
            done_cnt++;
            seen = 1'b1;
         end
         prev_rec = record;
         prev_freq = freq_step;
      end
      data_out_strobe = 1'b0;
      checkOutput("sweep_done_seen", 32'(seen), 32'd1);
      checkOutput("sweep_busy_at_done", 32'(busy), 32'd1);
      wait_cycle();
      checkOutput("sweep_busy_after_done", 32'(busy), 32'd0);
      checkOutput("sweep_windows", 32'(windows), 32'd3);
      checkOutput("sweep_rec_strobes", 32'(rec_strobes), 32'd12);
      checkOutput("sweep_freq_steps", 32'(freq_cnt), 32'd2);
      checkOutput("sweep_done_pulses", 32'(done_cnt), 32'd1);
      checkOutput("sweep_idx_sequence", 32'(idx_seq), 32'h012);
      checkOutput("sweep_step_overlap", 32'(viol), 32'd0);
      checkOutput("sweep_final_idx", 32'(step_index), 32'd2);

      // Abort during the second record window.
      windows = 0; done_cnt = 0; prev_rec = 1'b0;
      set_cfg(8'd3, 16'd2, 16'd3);
      start = 1'b1;
      for (cyc = 0; cyc < 500 && windows < 2; cyc++) begin
         data_out_strobe = (cyc % 5 == 4);
         wait_cycle();
         start = 1'b0;
         if (record && !prev_rec) windows++;
         if (done) done_cnt++;
         prev_rec = record;
      end
      checkOutput("abort_reached_window2", 32'(windows), 32'd2);
      checkOutput("abort_idx_in_window2", 32'(step_index), 32'd1);
      data_out_strobe = 1'b0;
      abort = 1'b1;
      wait_cycle();
      abort = 1'b0;
      checkOutput("abort_next_cycle", 32'(outs_now()), 32'(pack_out(0, 0, 8'd1, 0, 0, 1)));
      freq_cnt = 0; abort_cnt = 0; busy_cnt = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         data_out_strobe = (cyc % 5 == 4);
         wait_cycle();
         if (freq_step) freq_cnt++;
         if (done) done_cnt++;
         if (aborted) abort_cnt++;
         if (busy) busy_cnt++;
      end
      data_out_strobe = 1'b0;
      checkOutput("abort_quiet_after", 32'({freq_cnt[7:0], done_cnt[7:0], abort_cnt[7:0], busy_cnt[7:0]}), 32'd0);

      // Ignored start and config changes mid-sweep; strobe held high.
      first_rec_k = 0; freq_k = 0; done_k = 0; freq_cnt = 0; idx_at_done = 99;
      set_cfg(8'd2, 16'd3, 16'd1);
      data_out_strobe = 1'b1;
      start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         wait_cycle();
         start = 1'b0;
         if (k == 2) begin
            start = 1'b1;
            set_cfg(8'd5, 16'd9, 16'd7);
         end
         if (record && first_rec_k == 0) first_rec_k = k;
         if (freq_step) begin
            freq_cnt++;
            if (freq_k == 0) freq_k = k;
         end
         if (done && done_k == 0) begin
            done_k = k;
            idx_at_done = int'(step_index);
         end
      end
      data_out_strobe = 1'b0;
      checkOutput("ignore_first_record_k", 32'(first_rec_k), 32'd5);
      checkOutput("ignore_freq_k", 32'(freq_k), 32'd6);
      checkOutput("ignore_done_k", 32'(done_k), 32'd12);
      checkOutput("ignore_freq_count", 32'(freq_cnt), 32'd1);
      checkOutput("ignore_idx_at_done", 32'(idx_at_done), 32'd1);

      // Reset asserted in the STEP cycle, then a clean restart.
      set_cfg(8'd2, 16'd0, 16'd1);
      data_out_strobe = 1'b1;
      start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wait_cycle();
         start = 1'b0;
      end
      checkOutput("rst_step_reached", 32'(outs_now()), 32'(pack_out(1, 0, 8'd0, 1, 0, 0)));
      reset = 1'b1;
      start = 1'b1;
      abort = 1'b1;
      wait_cycle();
      checkOutput("rst_outputs_cleared", 32'(outs_now()), 32'(pack_out(0, 0, 8'd0, 0, 0, 0)));
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      wait_cycle();
      checkOutput("rst_no_pulse_after", 32'(outs_now()), 32'(pack_out(0, 0, 8'd0, 0, 0, 0)));
      done_k = 0; freq_k = 0; idx_at_k5 = 99; idx_at_done = 99;
      start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         wait_cycle();
         start = 1'b0;
         if (k == 5) idx_at_k5 = int'(step_index);
         if (freq_step && freq_k == 0) freq_k = k;
         if (done && done_k == 0) begin
            done_k = k;
            idx_at_done = int'(step_index);
         end
      end
      data_out_strobe = 1'b0;
      checkOutput("restart_freq_k", 32'(freq_k), 32'd4);
      checkOutput("restart_idx_k5", 32'(idx_at_k5), 32'd1);
      checkOutput("restart_done_k", 32'(done_k), 32'd8);
      checkOutput("restart_idx_at_done", 32'(idx_at_done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/fast_square_sweep_ctrl.md
FAST_SQUARE_SWEEP_CTRL -- requirements
Module: fast_square_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock, `clock`; `reset` SHALL be synchronous and active-high.
REQ-002 Parameter STEP_W, default 8, SHALL set the width of the step count and step index.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the settle and record counters.
REQ-004 clock  input  1  system clock; all logic updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle request to begin a sweep.
REQ-007 abort  input  1  terminates any sweep in progress.
REQ-008 num_steps  input  STEP_W  number of frequency points per sweep.
REQ-009 settle_cycles  input  CNT_W  clock cycles to wait after each retune.
REQ-010 record_samples  input  CNT_W  decimated samples to record per frequency point.
REQ-011 data_out_strobe  input  1  decimated-sample strobe from the comb/decimate chain.
REQ-012 freq_step  output  1  one-cycle pulse that advances the LO to the next frequency.
REQ-013 record  output  1  high while samples for the current point are being captured.
REQ-014 step_index  output  STEP_W  index of the current frequency point.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal sweep completion.
REQ-017 aborted  output  1  one-cycle pulse when an abort is taken.

Function
REQ-018 The FSM SHALL have exactly six states: IDLE, SETTLE, ALIGN, RECORD, STEP, DONE.
REQ-019 IDLE, start=1, abort=0, num_steps!=0 SHALL:
  - latch num_steps, settle_cycles and record_samples;
  - clear step_index to 0;
  - load the settle counter;
  - enter SETTLE next cycle.
REQ-020 IDLE, start=1, num_steps==0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-021 Latched configuration SHALL be used for the whole sweep; input changes mid-sweep SHALL be ignored.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 SETTLE SHALL remain for exactly settle_cycles clocks, then enter ALIGN; settle_cycles=0 SHALL mean one cycle in SETTLE.
REQ-024 ALIGN SHALL wait for data_out_strobe=1, then enter RECORD on the next cycle with the sample count cleared; strobes seen during SETTLE SHALL be ignored.
REQ-025 In RECORD, record SHALL be 1 and each data_out_strobe SHALL increment the sample count.
REQ-026 On the strobe that brings the sample count to the latched record_samples, record SHALL deassert on the next cycle.
REQ-027 record_samples=0 SHALL be treated as 1.
REQ-028 When RECORD exits: step_index==num_steps-1 SHALL go to DONE; otherwise it SHALL go to STEP.
REQ-029 STEP SHALL last exactly one cycle with freq_step=1, increment step_index, reload the settle counter, and enter SETTLE.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE; step_index SHALL hold its final value.
REQ-031 freq_step and record SHALL never be high in the same cycle.
REQ-032 freq_step SHALL never be high for two consecutive cycles.
REQ-033 abort=1 in any non-IDLE state SHALL, on the next cycle:
  - force IDLE;
  - drop record and freq_step;
  - pulse aborted for one cycle;
  - suppress done.
REQ-034 abort=1 in IDLE SHALL have no effect; abort SHALL take priority over a simultaneous start.
REQ-035 The settle and sample counters SHALL saturate, never wrap.
REQ-036 step_index SHALL never exceed num_steps-1.
REQ-037 Outputs SHALL be registered; no input SHALL reach an output combinationally.

Reset
REQ-038 reset SHALL force IDLE and drive freq_step=0, record=0, step_index=0, busy=0, done=0, aborted=0.
REQ-039 reset SHALL clear all counters and latched configuration on the next clock edge.
REQ-040 reset mid-sweep SHALL not pulse done or aborted.
REQ-041 reset SHALL take priority over start and abort.

Verification
REQ-042 Normal sweep: num_steps=3, settle=10, record=4, strobe every 17 clocks -> 3 record windows of 4 strobes each, 2 freq_step pulses, step_index goes 0,1,2, done pulses once, busy falls with done.
REQ-043 Zero-count edges: num_steps=0 -> done next cycle with busy=0 throughout; record_samples=0 -> a single-strobe record window per point.
REQ-044 Strobe alignment: strobe arriving during SETTLE -> no record; record rises only after the first strobe seen in ALIGN.
REQ-045 Abort: abort asserted during the second RECORD window -> record low next cycle, one aborted pulse, no done, busy=0, no further freq_step.
REQ-046 Ignored inputs: start pulsed during SETTLE and num_steps changed mid-sweep -> sweep timing and step count unchanged.
REQ-047 Reset mid-STEP: reset asserted in the STEP cycle -> all outputs at reset values on the next cycle; a new start then sweeps normally from step_index=0.
